// File: rtl/pkt_gen_bp_if.sv
`default_nettype none
// ============================================================================
// Module   : pkt_gen_bp_if
// Purpose  : Task-FIFO pop port and packet stream bundle for pkt_gen_bp.
// Revision : 1.0
// ============================================================================
interface pkt_gen_bp_if #(
    parameter int FLOW_CNT_WIDTH = 4,
    parameter int DATA_W         = 64,
    parameter int EMPTY_W        = 3
);
    logic [FLOW_CNT_WIDTH-1:0] pkt_task_str_i;
    logic [15:0]               pkt_task_size_i;
    logic                      pkt_task_val_i;
    logic                      pkt_task_rd_req_o;
    logic [DATA_W-1:0]         pkt_data_o;
    logic                      pkt_sop_o;
    logic                      pkt_eop_o;
    logic [EMPTY_W-1:0]        pkt_empty_o;
    logic                      pkt_val_o;
    logic [FLOW_CNT_WIDTH-1:0] pkt_flow_num_o;
    logic                      pkt_ready_i;

    modport master (
        input  pkt_task_str_i, pkt_task_size_i, pkt_task_val_i, pkt_ready_i,
        output pkt_task_rd_req_o, pkt_data_o, pkt_sop_o, pkt_eop_o,
        output pkt_empty_o, pkt_val_o, pkt_flow_num_o
    );

    modport slave (
        output pkt_task_str_i, pkt_task_size_i, pkt_task_val_i, pkt_ready_i,
        input  pkt_task_rd_req_o, pkt_data_o, pkt_sop_o, pkt_eop_o,
        input  pkt_empty_o, pkt_val_o, pkt_flow_num_o
    );
endinterface
`default_nettype wire

// File: rtl/pkt_gen_bp.sv
`default_nettype none
// ============================================================================
// Module   : pkt_gen_bp
// Purpose  : Multi-flow packet generator with backpressure; word 0 carries a
//            flow/seq/size header. PKT_GEN_SEQ_NUM_EN enables per-flow seq counters.
// Revision : 1.0
// ============================================================================
module pkt_gen_bp #(
    parameter int FLOW_CNT       = 16,
    parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
    parameter int DATA_W         = 64,
    parameter int BYTES          = DATA_W / 8,
    parameter int EMPTY_W        = $clog2(BYTES),
    parameter int FORCE_IDLE     = 0
) (
    input  wire logic    clk_i,
    input  wire logic    rst_n_i,
    pkt_gen_bp_if.master bus
);

    generate
        if (DATA_W < 64 || (DATA_W & (DATA_W - 1)) != 0 || FLOW_CNT < 1) begin : g_cfg_check
            $error("pkt_gen_bp: DATA_W must be a power of two >= 64 and FLOW_CNT >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_TX = 1'b1} state_t;

    state_t                    r_state;
    logic [15:0]               r_size;
    logic [15:0]               r_word_cnt;
    logic [FLOW_CNT_WIDTH-1:0] r_flow;
    logic                      r_val;
    logic                      r_sop;
    logic                      r_eop;
    logic [EMPTY_W-1:0]        r_empty;
    logic [DATA_W-1:0]         r_data;

    logic        w_hs;
    logic        w_eop_hs;
    logic        w_rd_req;
    logic [15:0] w_new_last;
    logic [15:0] w_cur_last;
    logic [15:0] w_next_cnt;
    logic [31:0] w_hdr_mid;

    // Builds one output word: header in word 0, byte index elsewhere, zeros past the end.
    function automatic logic [DATA_W-1:0] f_word(
        input logic [15:0]               wcnt,
        input logic [15:0]               size,
        input logic [FLOW_CNT_WIDTH-1:0] flow,
        input logic [31:0]               mid
    );
        logic [DATA_W-1:0] d;
        logic [63:0]       hdr;
        logic [31:0]       idx;
        logic [7:0]        bval;
        d   = '0;
        hdr = {16'(flow), mid, size};
        for (int b = 0; b < BYTES; b++) begin
            idx = {16'd0, wcnt} * 32'(BYTES) + 32'(b);
            if (wcnt == 16'd0 && b < 8) bval = hdr[63-8*b -: 8];
            else                        bval = idx[7:0];
            if (idx >= {16'd0, size}) bval = 8'h00;
            d[DATA_W-1-8*b -: 8] = bval;
        end
        return d;
    endfunction

    assign w_hs       = r_val & bus.pkt_ready_i;
    assign w_eop_hs   = w_hs & r_eop;
    assign w_rd_req   = rst_n_i && bus.pkt_task_val_i &&
                        ((r_state == S_IDLE) || (w_eop_hs && (FORCE_IDLE == 0)));
    assign w_new_last = (bus.pkt_task_size_i - 16'd1) >> EMPTY_W;
    assign w_cur_last = (r_size - 16'd1) >> EMPTY_W;
    assign w_next_cnt = r_word_cnt + 16'd1;

`ifdef PKT_GEN_SEQ_NUM_EN
    logic [FLOW_CNT-1:0][31:0] r_seq;

    // Back-to-back on the same flow must see the increment of the packet ending now.
    always_comb begin
        w_hdr_mid = r_seq[bus.pkt_task_str_i];
        if (w_eop_hs && (bus.pkt_task_str_i == r_flow)) w_hdr_mid = w_hdr_mid + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)      r_seq         <= '0;
        else if (w_eop_hs) r_seq[r_flow] <= r_seq[r_flow] + 32'd1;
    end
`else
    assign w_hdr_mid = 32'h0203_0405;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_size     <= '0;
            r_word_cnt <= '0;
            r_flow     <= '0;
            r_val      <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_empty    <= '0;
            r_data     <= '0;
        end else if (w_rd_req) begin
            if (bus.pkt_task_size_i == 16'd0) begin
                // Zero-size task: popped and dropped.
                r_state <= S_IDLE;
                r_val   <= 1'b0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
                r_empty <= '0;
            end else begin
                r_state    <= S_TX;
                r_size     <= bus.pkt_task_size_i;
                r_flow     <= bus.pkt_task_str_i;
                r_word_cnt <= '0;
                r_val      <= 1'b1;
                r_sop      <= 1'b1;
                r_eop      <= (w_new_last == 16'd0);
                r_empty    <= (w_new_last == 16'd0) ? EMPTY_W'(16'd0 - bus.pkt_task_size_i) : '0;
                r_data     <= f_word(16'd0, bus.pkt_task_size_i, bus.pkt_task_str_i, w_hdr_mid);
            end
        end else if (w_eop_hs) begin
            r_state <= S_IDLE;
            r_val   <= 1'b0;
        end else if (w_hs) begin
            r_word_cnt <= w_next_cnt;
            r_sop      <= 1'b0;
            r_eop      <= (w_next_cnt == w_cur_last);
            r_empty    <= (w_next_cnt == w_cur_last) ? EMPTY_W'(16'd0 - r_size) : '0;
            r_data     <= f_word(w_next_cnt, r_size, r_flow, 32'd0);
        end
    end

    assign bus.pkt_task_rd_req_o = w_rd_req;
    assign bus.pkt_data_o        = r_data;
    assign bus.pkt_sop_o         = r_sop;
    assign bus.pkt_eop_o         = r_eop;
    assign bus.pkt_empty_o       = r_empty;
    assign bus.pkt_val_o         = r_val;
    assign bus.pkt_flow_num_o    = r_flow;

endmodule
`default_nettype wire

// File: tb/tb_pkt_gen_bp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_gen_bp
// Purpose  : Self-checking bench for pkt_gen_bp (DATA_W=64, 16 flows).
// Revision : 1.0
// ============================================================================
module tb_pkt_gen_bp;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [3:0]  flow;
    } word_t;

    typedef struct {
        logic [3:0]  flow;
        logic [15:0] size;
    } task_t;

    typedef struct {
        logic [3:0]  flow;
        logic [15:0] size;
        int          words;
        logic [2:0]  empty;
        logic [63:0] w0;
        logic [63:0] wlast;
    } vec_t;

`ifdef PKT_GEN_SEQ_NUM_EN
    localparam logic [31:0] MID = 32'h0000_0000;
`else
    localparam logic [31:0] MID = 32'h0203_0405;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_gen_bp_if #(.FLOW_CNT_WIDTH(4), .DATA_W(64), .EMPTY_W(3)) bus0 ();
    pkt_gen_bp_if #(.FLOW_CNT_WIDTH(4), .DATA_W(64), .EMPTY_W(3)) bus1 ();

    pkt_gen_bp #(.FLOW_CNT(16), .DATA_W(64), .FORCE_IDLE(0)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
    pkt_gen_bp #(.FLOW_CNT(16), .DATA_W(64), .FORCE_IDLE(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        rand_mode = 1'b0;
    task_t       tq[$];
    word_t       exp_q[$];
    logic [31:0] mseq [16];
    int          pop_cycs[$], sop_cycs[$], eop_cycs[$];
    logic [63:0] xfer_data[$];
    logic [2:0]  eop_empty[$];
    logic        have_prev = 1'b0;
    logic [73:0] prev_snap;
    logic [73:0] cur_snap;
    vec_t        vt[6];

    // Reference: byte-array packet image chopped into 8-byte words.
    task automatic gen_pkt(input logic [3:0] flow, input logic [15:0] size);
        logic [7:0]  pb[$];
        logic [63:0] hdr;
        word_t       w;
        int          nw;
        if (size == 16'd0) return;
`ifdef PKT_GEN_SEQ_NUM_EN
        hdr = {12'h000, flow, mseq[flow], size};
        mseq[flow] = mseq[flow] + 32'd1;
`else
        hdr = {12'h000, flow, 32'h0203_0405, size};
`endif
        for (int i = 0; i < int'(size); i++) begin
            if (i < 8) pb.push_back(hdr[63-8*i -: 8]);
            else       pb.push_back(8'(i));
        end
        nw = (int'(size) + 7) / 8;
        while (pb.size() < nw * 8) pb.push_back(8'h00);
        for (int k = 0; k < nw; k++) begin
            for (int j = 0; j < 8; j++) w.data[63-8*j -: 8] = pb[8*k+j];
            w.sop   = (k == 0);
            w.eop   = (k == nw - 1);
            w.empty = (k == nw - 1) ? 3'((8 - int'(size) % 8) % 8) : 3'd0;
            w.flow  = flow;
            exp_q.push_back(w);
        end
    endtask

    task automatic clear_logs();
        pop_cycs.delete(); sop_cycs.delete(); eop_cycs.delete();
        xfer_data.delete(); eop_empty.delete();
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_idle(input int limit, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #2;
            if (tq.size() == 0 && exp_q.size() == 0 && !bus0.pkt_val_o) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, limit);
        end
    endtask

    // Driver, show-ahead task FIFO and scoreboard for dut0.
    always @(negedge clk) begin
        word_t e;
        task_t t;
        cyc++;
        bus0.pkt_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tq.size() > 0) begin
            bus0.pkt_task_val_i  = 1'b1;
            bus0.pkt_task_str_i  = tq[0].flow;
            bus0.pkt_task_size_i = tq[0].size;
        end else begin
            bus0.pkt_task_val_i  = 1'b0;
        end
        #1;
        cur_snap = {bus0.pkt_val_o, bus0.pkt_sop_o, bus0.pkt_eop_o, bus0.pkt_empty_o,
                    bus0.pkt_flow_num_o, bus0.pkt_data_o};
        if (!rst_n) begin
            n_cmp++;
            if (bus0.pkt_task_rd_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_req_in_reset: got %b, required 0", bus0.pkt_task_rd_req_o);
            end
            exp_q.delete();
            for (int i = 0; i < 16; i++) mseq[i] = 32'd0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                n_cmp++;
                if (cur_snap !== prev_snap) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h, required %h", cur_snap, prev_snap);
                end
            end
            if (bus0.pkt_task_rd_req_o === 1'b1) begin
                pop_cycs.push_back(cyc);
                if (tq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pop_empty: got rd_req 1 with no task, required 0");
                end else begin
                    t = tq.pop_front();
                    gen_pkt(t.flow, t.size);
                end
            end
            if (bus0.pkt_val_o === 1'b1 && bus0.pkt_ready_i === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL word_unexpected: got data=%h sop=%b eop=%b, required no word",
                             bus0.pkt_data_o, bus0.pkt_sop_o, bus0.pkt_eop_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus0.pkt_data_o !== e.data || bus0.pkt_sop_o !== e.sop || bus0.pkt_eop_o !== e.eop ||
                        bus0.pkt_empty_o !== e.empty || bus0.pkt_flow_num_o !== e.flow) begin
                        n_fail++;
                        $display("FAIL word: got data=%h sop=%b eop=%b empty=%0d flow=%0d, required data=%h sop=%b eop=%b empty=%0d flow=%0d",
                                 bus0.pkt_data_o, bus0.pkt_sop_o, bus0.pkt_eop_o, bus0.pkt_empty_o, bus0.pkt_flow_num_o,
                                 e.data, e.sop, e.eop, e.empty, e.flow);
                    end
                end
                xfer_data.push_back(bus0.pkt_data_o);
                if (bus0.pkt_sop_o) sop_cycs.push_back(cyc);
                if (bus0.pkt_eop_o) begin
                    eop_cycs.push_back(cyc);
                    eop_empty.push_back(bus0.pkt_empty_o);
                end
            end
            have_prev = bus0.pkt_val_o & ~bus0.pkt_ready_i;
            prev_snap = cur_snap;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("[TB] %0d tests run, %0d failed", n_cmp + 1, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        task_t t;
        int    p1;
        int    s1[$], e1[$];
        bit    ok;

        vt[0] = '{4'd3, 16'd64, 8, 3'd0, {16'h0003, MID, 16'h0040}, 64'h3839_3A3B_3C3D_3E3F};
        vt[1] = '{4'd7, 16'd61, 8, 3'd3, {16'h0007, MID, 16'h003D}, 64'h3839_3A3B_3C00_0000};
        vt[2] = '{4'd1, 16'd1,  1, 3'd7, 64'h0,                    64'h0};
        vt[3] = '{4'd2, 16'd8,  1, 3'd0, {16'h0002, MID, 16'h0008}, {16'h0002, MID, 16'h0008}};
        vt[4] = '{4'd4, 16'd9,  2, 3'd7, {16'h0004, MID, 16'h0009}, 64'h0800_0000_0000_0000};
        vt[5] = '{4'd6, 16'd0,  0, 3'd0, 64'h0,                    64'h0};

        bus1.pkt_ready_i = 1'b1; bus1.pkt_task_val_i = 1'b0;
        bus1.pkt_task_str_i = 4'd5; bus1.pkt_task_size_i = 16'd16;
        bus0.pkt_task_str_i = 4'd0; bus0.pkt_task_size_i = 16'd0;
        for (int i = 0; i < 16; i++) mseq[i] = 32'd0;

        // A task is already waiting while reset is held: it must not be popped.
        t.flow = 4'd9; t.size = 16'd8;
        tq.push_back(t);
        repeat (2) @(negedge clk);
        #2;
        check("reset_outputs",
              {48'd0, bus0.pkt_val_o, bus0.pkt_sop_o, bus0.pkt_eop_o, bus0.pkt_empty_o,
               bus0.pkt_flow_num_o, bus0.pkt_task_rd_req_o},
              64'd0);
        check("reset_data", bus0.pkt_data_o, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_idle(100, "first_task");

`ifdef PKT_GEN_SEQ_NUM_EN
        @(posedge clk); #2;
        force dut0.r_seq = {{15{32'h0}}, 32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++) mseq[i] = 32'd0;
        mseq[0] = 32'hFFFF_FFFF;
        @(posedge clk); #2;
        release dut0.r_seq;
        clear_logs();
        t.flow = 4'd0; t.size = 16'd8;
        tq.push_back(t); tq.push_back(t);
        wait_idle(100, "seq_wrap");
        check("wrap_words", 64'(xfer_data.size()), 64'd2);
        if (xfer_data.size() == 2) begin
            check("wrap_seq0", 64'(xfer_data[0][47:16]), 64'hFFFF_FFFF);
            check("wrap_seq1", 64'(xfer_data[1][47:16]), 64'h0);
        end
`endif

        // Table vectors with ready held high.
        rand_mode = 1'b0;
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            t.flow = vt[v].flow; t.size = vt[v].size;
            tq.push_back(t);
            wait_idle(100, "table");
            check("tbl_pops", 64'(pop_cycs.size()), 64'd1);
            check("tbl_words", 64'(xfer_data.size()), 64'(vt[v].words));
            if (vt[v].words > 0 && xfer_data.size() == vt[v].words && pop_cycs.size() == 1 &&
                sop_cycs.size() == 1 && eop_cycs.size() == 1) begin
                check("tbl_word0", xfer_data[0], vt[v].w0);
                check("tbl_wlast", xfer_data[vt[v].words-1], vt[v].wlast);
                check("tbl_empty", 64'(eop_empty[0]), 64'(vt[v].empty));
                check("tbl_latency", 64'(sop_cycs[0] - pop_cycs[0]), 64'd1);
                check("tbl_eop_pos", 64'(eop_cycs[0] - sop_cycs[0]), 64'(vt[v].words - 1));
            end
        end

        // Back-to-back on flow 5 without a bubble.
        clear_logs();
        t.flow = 4'd5; t.size = 16'd16;
        tq.push_back(t); tq.push_back(t);
        wait_idle(100, "b2b");
        check("b2b_pops", 64'(pop_cycs.size()), 64'd2);
        check("b2b_words", 64'(xfer_data.size()), 64'd4);
        if (pop_cycs.size() == 2 && sop_cycs.size() == 2 && eop_cycs.size() == 2 && xfer_data.size() == 4) begin
            check("b2b_rdreq_on_eop", 64'(pop_cycs[1]), 64'(eop_cycs[0]));
            check("b2b_no_gap", 64'(sop_cycs[1] - eop_cycs[0]), 64'd1);
`ifdef PKT_GEN_SEQ_NUM_EN
            check("b2b_seq0", 64'(xfer_data[0][47:16]), 64'd0);
            check("b2b_seq1", 64'(xfer_data[2][47:16]), 64'd1);
`endif
        end

        // Same pair on the FORCE_IDLE=1 instance: exactly one idle cycle.
        p1 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus1.pkt_task_val_i = (p1 < 2);
            #1;
            if (bus1.pkt_task_rd_req_o === 1'b1) p1++;
            if (bus1.pkt_val_o === 1'b1) begin
                if (bus1.pkt_sop_o) s1.push_back(c);
                if (bus1.pkt_eop_o) e1.push_back(c);
            end
        end
        bus1.pkt_task_val_i = 1'b0;
        check("fi_pops", 64'(p1), 64'd2);
        check("fi_pkts", 64'(s1.size() + e1.size()), 64'd4);
        if (s1.size() == 2 && e1.size() == 2)
            check("fi_one_idle", 64'(s1[1] - e1[0]), 64'd2);

        // Random traffic with 50% ready.
        rand_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            t.flow = 4'($urandom_range(0, 15));
            t.size = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 1518));
            tq.push_back(t);
            ok = 1'b0;
            for (int g = 0; g < 4000; g++) begin
                if (tq.size() < 2) begin ok = 1'b1; break; end
                @(posedge clk); #2;
            end
            if (!ok) check("rand_fifo_drain", 64'(tq.size()), 64'd1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
        end
        wait_idle(6000, "random");
        rand_mode = 1'b0;

        // Reset in the middle of a 10-word packet.
        clear_logs();
        t.flow = 4'd8; t.size = 16'd80;
        tq.push_back(t);
        ok = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk); #2;
            if (xfer_data.size() >= 3) begin ok = 1'b1; break; end
        end
        check("rst_reach_word3", 64'(ok), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #2;
        check("rst_val_drop", 64'(bus0.pkt_val_o), 64'd0);
        clear_logs();
        t.flow = 4'd8; t.size = 16'd16;
        tq.push_back(t);
        wait_idle(100, "after_reset");
        check("rst_next_words", 64'(xfer_data.size()), 64'd2);
        if (xfer_data.size() == 2 && sop_cycs.size() == 1) begin
            check("rst_next_word0", xfer_data[0], {16'h0008, MID, 16'h0010});
            check("rst_next_latency", 64'(sop_cycs[0] - pop_cycs[0]), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
